// File: rtl/mem_seq.sv
// mem_seq: single-outstanding load/store sequencer between execute stage and data bus.
// Optional split (two-beat) handling of word-crossing accesses under `MEM_MISALIGN_EN`.
package mem_ctrl_pkg;
    typedef enum logic [2:0] {
        NONE, READ_B, READ_H, READ_W, STORE_B, STORE_H, STORE_W
    } mem_ctrl_t;
endpackage

module mem_seq
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  mem_ctrl_t   mem_ctrl,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

`ifdef MEM_MISALIGN_EN
    typedef enum logic [2:0] {IDLE, REQ, RESP, REQ2, RESP2, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
`endif

    // 0 = byte, 1 = half, 2 = word
    function automatic logic [1:0] acc_size(input mem_ctrl_t c);
        case (c)
            READ_H, STORE_H: return 2'd1;
            READ_W, STORE_W: return 2'd2;
            default:         return 2'd0;
        endcase
    endfunction

    function automatic logic acc_store(input mem_ctrl_t c);
        return (c == STORE_B) || (c == STORE_H) || (c == STORE_W);
    endfunction

    function automatic logic [3:0] base_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_lo(input logic [1:0] sz, input logic [1:0] off,
                                            input logic [31:0] wd);
        if (sz == 2'd0)
            return {4{wd[7:0]}};
        if (sz == 2'd1 && !off[0])
            return {2{wd[15:0]}};
        return wd << {off, 3'b000};
    endfunction

`ifdef MEM_MISALIGN_EN
    // Bytes of a crossing access that spill into the following word.
    function automatic logic [31:0] lane_hi(input logic [1:0] off, input logic [31:0] wd);
        if (off == 2'd0)
            return 32'd0;
        return wd >> (6'd32 - {1'b0, off, 3'b000});
    endfunction
`endif

    function automatic logic [31:0] extend(input mem_ctrl_t c, input logic uns,
                                           input logic [31:0] sh);
        case (acc_size(c))
            2'd0:    return uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    mem_ctrl_t     ctrl_reg, ctrl_next;
    logic          uns_reg, uns_next;
    logic [1:0]    off_reg, off_next;
    logic          done_reg, done_next;
    logic          fault_reg, fault_next;
    logic [31:0]   rdata_reg, rdata_next;
    logic          bus_req_reg, bus_req_next;
    logic          bus_we_reg, bus_we_next;
    logic [31:0]   bus_addr_reg, bus_addr_next;
    logic [31:0]   bus_wdata_reg, bus_wdata_next;
    logic [3:0]    bus_strb_reg, bus_strb_next;
`ifdef MEM_MISALIGN_EN
    logic          split_reg, split_next;
    logic [31:0]   lo_reg, lo_next;
    logic [3:0]    strb_hi_reg, strb_hi_next;
    logic [31:0]   wdata_hi_reg, wdata_hi_next;
    logic [5:0]    sh_amt;
`endif

    logic          timed_out;
    logic          abort;
    logic          misalign;
    logic [1:0]    in_size;
    logic [31:0]   ld_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            ctrl_reg      <= NONE;
            uns_reg       <= 1'b0;
            off_reg       <= 2'd0;
            done_reg      <= 1'b0;
            fault_reg     <= 1'b0;
            rdata_reg     <= 32'd0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= 32'd0;
            bus_wdata_reg <= 32'd0;
            bus_strb_reg  <= 4'd0;
`ifdef MEM_MISALIGN_EN
            split_reg     <= 1'b0;
            lo_reg        <= 32'd0;
            strb_hi_reg   <= 4'd0;
            wdata_hi_reg  <= 32'd0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            ctrl_reg      <= ctrl_next;
            uns_reg       <= uns_next;
            off_reg       <= off_next;
            done_reg      <= done_next;
            fault_reg     <= fault_next;
            rdata_reg     <= rdata_next;
            bus_req_reg   <= bus_req_next;
            bus_we_reg    <= bus_we_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            bus_strb_reg  <= bus_strb_next;
`ifdef MEM_MISALIGN_EN
            split_reg     <= split_next;
            lo_reg        <= lo_next;
            strb_hi_reg   <= strb_hi_next;
            wdata_hi_reg  <= wdata_hi_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        ctrl_next      = ctrl_reg;
        uns_next       = uns_reg;
        off_next       = off_reg;
        done_next      = 1'b0;
        fault_next     = 1'b0;
        rdata_next     = rdata_reg;
        bus_req_next   = bus_req_reg;
        bus_we_next    = bus_we_reg;
        bus_addr_next  = bus_addr_reg;
        bus_wdata_next = bus_wdata_reg;
        bus_strb_next  = bus_strb_reg;
        abort          = 1'b0;
        timed_out      = (cnt_reg == CW'(TIMEOUT_CYC - 1));
        in_size        = acc_size(mem_ctrl);
        ld_sh          = bus_rdata >> {off_reg, 3'b000};
`ifdef MEM_MISALIGN_EN
        split_next     = split_reg;
        lo_next        = lo_reg;
        strb_hi_next   = strb_hi_reg;
        wdata_hi_next  = wdata_hi_reg;
        sh_amt         = {1'b0, off_reg, 3'b000};
        misalign       = 1'b0;
`else
        misalign       = (in_size == 2'd1 && addr[0]) || (in_size == 2'd2 && addr[1:0] != 2'd0);
`endif

        case (state_reg)
            IDLE: begin
                if (start) begin
                    ctrl_next = mem_ctrl;
                    uns_next  = load_unsigned;
                    off_next  = addr[1:0];
                    cnt_next  = '0;
                    if (mem_ctrl == NONE) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                        rdata_next = 32'd0;
                    end else if (misalign) begin
                        abort = 1'b1;
                    end else begin
                        state_next     = REQ;
                        bus_req_next   = 1'b1;
                        bus_we_next    = acc_store(mem_ctrl);
                        bus_addr_next  = {addr[31:2], 2'b00};
                        bus_strb_next  = acc_store(mem_ctrl) ? (base_mask(in_size) << addr[1:0]) : 4'd0;
                        bus_wdata_next = lane_lo(in_size, addr[1:0], wdata);
`ifdef MEM_MISALIGN_EN
                        split_next    = ({1'b0, addr[1:0]} + {1'b0, in_size == 2'd2, in_size == 2'd1,
                                         in_size == 2'd0}) > 3'd4;
                        strb_hi_next  = acc_store(mem_ctrl) ?
                                        (base_mask(in_size) >> (3'd4 - {1'b0, addr[1:0]})) : 4'd0;
                        wdata_hi_next = lane_hi(addr[1:0], wdata);
`endif
                    end
                end
            end
            REQ: begin
                cnt_next = cnt_reg + CW'(1);
                if (bus_gnt) begin
                    state_next   = RESP;
                    cnt_next     = '0;
                    bus_req_next = 1'b0;
                end else if (timed_out) begin
                    abort = 1'b1;
                end
            end
            RESP: begin
                cnt_next = cnt_reg + CW'(1);
                if (bus_rvalid) begin
`ifdef MEM_MISALIGN_EN
                    if (split_reg) begin
                        lo_next        = bus_rdata;
                        state_next     = REQ2;
                        cnt_next       = '0;
                        bus_req_next   = 1'b1;
                        bus_addr_next  = bus_addr_reg + 32'd4;
                        bus_strb_next  = strb_hi_reg;
                        bus_wdata_next = wdata_hi_reg;
                    end else
`endif
                    begin
                        state_next = DONE;
                        done_next  = 1'b1;
                        rdata_next = acc_store(ctrl_reg) ? 32'd0 : extend(ctrl_reg, uns_reg, ld_sh);
                    end
                end else if (timed_out) begin
                    abort = 1'b1;
                end
            end
`ifdef MEM_MISALIGN_EN
            REQ2: begin
                cnt_next = cnt_reg + CW'(1);
                if (bus_gnt) begin
                    state_next   = RESP2;
                    cnt_next     = '0;
                    bus_req_next = 1'b0;
                end else if (timed_out) begin
                    abort = 1'b1;
                end
            end
            RESP2: begin
                cnt_next = cnt_reg + CW'(1);
                if (bus_rvalid) begin
                    // A split access always has off != 0, so both shifts stay below 32.
                    state_next = DONE;
                    done_next  = 1'b1;
                    rdata_next = acc_store(ctrl_reg) ? 32'd0 :
                                 extend(ctrl_reg, uns_reg, (lo_reg >> sh_amt) | (bus_rdata << (6'd32 - sh_amt)));
                end else if (timed_out) begin
                    abort = 1'b1;
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (abort) begin
            state_next   = DONE;
            bus_req_next = 1'b0;
            done_next    = 1'b1;
            fault_next   = 1'b1;
            rdata_next   = 32'd0;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign fault     = fault_reg;
    assign rdata     = rdata_reg;
    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign bus_strb  = bus_strb_reg;

endmodule

// File: tb/tb_mem_seq.sv
// Self-checking bench for mem_seq: directed test-plan cases plus randomized accesses
// against a byte-level reference model; bench acts as the bus slave.
module tb_mem_seq;
    import mem_ctrl_pkg::*;

    localparam int T = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    mem_ctrl_t   mem_ctrl;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_strb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    mem_seq #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_ctrl(mem_ctrl),
        .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .fault(fault), .rdata(rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_strb(bus_strb), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input mem_ctrl_t c);
        case (c)
            READ_B, STORE_B: return 1;
            READ_H, STORE_H: return 2;
            READ_W, STORE_W: return 4;
            default:         return 0;
        endcase
    endfunction

    function automatic logic is_store(input mem_ctrl_t c);
        return (c == STORE_B) || (c == STORE_H) || (c == STORE_W);
    endfunction

    // gd/rd: cycles the slave waits before gnt / rvalid (>= T forces a timeout)
    task automatic do_access(input mem_ctrl_t c, input logic uns, input logic [31:0] a,
                             input logic [31:0] wd, input int gd, input int rd,
                             input logic [31:0] r1, input logic [31:0] r2, input logic extra);
        int n, off, nb, d_exp, req_exp, t, cyc, beat, rw, vw, req_cnt, d_obs, p;
        logic f_exp, f_obs, mis, got_done, resp_phase;
        logic [31:0] r_exp, r_obs, val, exp_wd, care;
        logic [7:0] by;
        logic [3:0] exp_strb;

        n   = nbytes(c);
        off = int'(a[1:0]);
`ifdef MEM_MISALIGN_EN
        mis = 1'b0;
`else
        mis = (n == 2 && (off % 2) == 1) || (n == 4 && off != 0);
`endif
        nb      = (off + n > 4) ? 2 : 1;
        f_exp   = 1'b0;
        r_exp   = 32'd0;
        req_exp = 0;
        if (n == 0) begin
            d_exp = 1;
        end else if (mis) begin
            d_exp = 1;
            f_exp = 1'b1;
        end else begin
            t = 1;
            d_exp = 0;
            for (int b = 0; b < nb; b++) begin
                if (gd >= T) begin
                    d_exp = t + T; f_exp = 1'b1; req_exp += T; break;
                end
                req_exp += gd + 1;
                if (rd >= T) begin
                    d_exp = t + gd + 1 + T; f_exp = 1'b1; break;
                end
                t += gd + rd + 2;
            end
            if (!f_exp) d_exp = t;
        end
        if (n != 0 && !f_exp && !is_store(c)) begin
            val = 32'd0;
            for (int k = 0; k < n; k++) begin
                p  = off + k;
                by = (p < 4) ? r1[8*p +: 8] : r2[8*(p-4) +: 8];
                val = val | (32'(by) << (8 * k));
            end
            if (uns || n == 4)      r_exp = val;
            else if (n == 1)        r_exp = val[7]  ? (val | 32'hFFFF_FF00) : val;
            else                    r_exp = val[15] ? (val | 32'hFFFF_0000) : val;
        end

        @(negedge clk);
        start = 1'b1; mem_ctrl = c; load_unsigned = uns; addr = a; wdata = wd;
        cyc = 0; beat = 0; rw = 0; vw = 0; req_cnt = 0; got_done = 1'b0; resp_phase = 1'b0;
        d_obs = -1; f_obs = 1'b0; r_obs = 32'd0;
        while (!got_done && cyc < 4 * T + 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                check("busy_cyc1", busy, 1'b1);
            end
            if (extra && cyc == 2) begin
                start = 1'b1; mem_ctrl = NONE; addr = $urandom;
            end
            if (cyc == 3) start = 1'b0;
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
            if (done) begin
                got_done = 1'b1; d_obs = cyc; f_obs = fault; r_obs = rdata;
            end else if (bus_req) begin
                req_cnt++;
                if (rw == 0) begin
                    exp_strb = 4'd0; exp_wd = 32'd0; care = 32'd0;
                    for (int k = 0; k < n; k++) begin
                        p = off + k;
                        if (p / 4 == beat) begin
                            exp_strb[p % 4] = 1'b1;
                            exp_wd[8*(p%4) +: 8] = wd[8*k +: 8];
                            care[8*(p%4) +: 8] = 8'hFF;
                        end
                    end
                    if (n == 1) begin
                        exp_wd = {4{wd[7:0]}}; care = 32'hFFFF_FFFF;
                    end else if (n == 2 && (off % 2) == 0) begin
                        exp_wd = {2{wd[15:0]}}; care = 32'hFFFF_FFFF;
                    end
                    check("bus_addr", bus_addr, (beat == 0) ? {a[31:2], 2'b00} : {a[31:2], 2'b00} + 32'd4);
                    check("bus_we", bus_we, is_store(c));
                    check("bus_strb", bus_strb, is_store(c) ? exp_strb : 4'd0);
                    if (is_store(c)) check("bus_wdata", bus_wdata & care, exp_wd & care);
                end
                if (rw == gd) begin
                    bus_gnt = 1'b1; resp_phase = 1'b1; rw = 0; vw = 0;
                end else begin
                    rw++;
                end
            end else if (resp_phase) begin
                if (vw == rd) begin
                    bus_rvalid = 1'b1;
                    bus_rdata = (beat == 0) ? r1 : r2;
                    beat++;
                    resp_phase = 1'b0;
                end else begin
                    vw++;
                end
            end
        end
        start = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        if (!got_done) check("done_wait", 1'b0, 1'b1);
        check("done_cycle", d_obs, d_exp);
        check("fault", f_obs, f_exp);
        check("req_cycles", req_cnt, req_exp);
        if (!is_store(c) || f_exp) check("rdata", r_obs, r_exp);
        @(negedge clk);
        check("done_pulse", done, 1'b0);
        check("busy_after", busy, 1'b0);
        if (!is_store(c) || f_exp) check("rdata_held", rdata, r_exp);
        $display("txn ctrl=%s uns=%0b addr=%08h wdata=%08h gd=%0d rd=%0d done_cyc=%0d fault=%0b rdata=%08h",
                 c.name(), uns, a, wd, gd, rd, d_obs, f_obs, r_obs);
    endtask

    initial begin
        mem_ctrl_t rc;
        int gd, rd;
        rst = 1'b1; start = 1'b0; mem_ctrl = NONE; load_unsigned = 1'b0;
        addr = 32'd0; wdata = 32'd0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", {busy, done, fault, bus_req, bus_we, bus_strb}, 9'd0);
        check("reset_data", {rdata, bus_addr}, 64'd0);
        check("reset_wdata", bus_wdata, 32'd0);
        rst = 1'b0;

        do_access(STORE_B, 1'b0, 32'h0000_1002, 32'h0000_00AB, 0, 0, 32'd0, 32'd0, 1'b0);
        do_access(READ_H,  1'b0, 32'h0000_2002, 32'd0, 0, 0, 32'h8001_1234, 32'd0, 1'b0);
        do_access(READ_H,  1'b1, 32'h0000_2002, 32'd0, 0, 0, 32'h8001_1234, 32'd0, 1'b0);
        do_access(READ_W,  1'b0, 32'h0000_5000, 32'd0, T + 3, 0, 32'h1234_5678, 32'd0, 1'b0);
        do_access(STORE_W, 1'b0, 32'h0000_5004, 32'hDEAD_BEEF, 1, T + 1, 32'd0, 32'd0, 1'b0);
        do_access(READ_W,  1'b0, 32'h0000_3001, 32'd0, 0, 0, 32'h4433_2211, 32'h8877_6655, 1'b0);
        do_access(READ_B,  1'b0, 32'h0000_4003, 32'd0, 2, 1, 32'h9A00_0000, 32'd0, 1'b1);
        do_access(NONE,    1'b0, 32'h0000_4000, 32'd0, 0, 0, 32'd0, 32'd0, 1'b0);
        do_access(STORE_H, 1'b0, 32'hFFFF_FFFF, 32'h0000_CAFE, 0, 0, 32'd0, 32'd0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            rc = mem_ctrl_t'($urandom_range(0, 6));
            gd = ($urandom_range(0, 15) == 0) ? T + 2 : int'($urandom_range(0, 3));
            rd = ($urandom_range(0, 15) == 0) ? T + 1 : int'($urandom_range(0, 3));
            do_access(rc, 1'($urandom_range(0, 1)), $urandom, $urandom, gd, rd,
                      $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        do_access(READ_W, 1'b0, 32'h0000_7000, 32'd0, 0, 0, 32'hA5A5_0F0F, 32'd0, 1'b0);
        @(negedge clk);
        start = 1'b1; mem_ctrl = READ_W; load_unsigned = 1'b0; addr = 32'h0000_0040;
        @(negedge clk);
        start = 1'b0;
        check("rst_seq_req", bus_req, 1'b1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        check("rst_seq_resp", {busy, bus_req}, 2'b10);
        rst = 1'b1;
        #1;
        check("rst_mid_ctrl", {busy, done, fault, bus_req, bus_we, bus_strb}, 9'd0);
        check("rst_mid_data", {rdata, bus_addr}, 64'd0);
        check("rst_mid_wdata", bus_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_access(READ_B, 1'b1, 32'h0000_0041, 32'd0, 0, 0, 32'h0000_F000, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
